// File: rtl/imem_loader.sv
// Boot loader: parses a length/words/checksum byte stream into instruction-memory
// writes and holds the CPU in reset until a verified image is in place.
module imem_loader #(
   parameter logic [7:0] BASE_ADDR = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [7:0]  imem_addr,
   output logic [15:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t      state;
   logic [7:0]  sum;
   logic [7:0]  words_left;
   logic [7:0]  addr_ptr;
   logic [7:0]  hi_byte;
   logic [15:0] word_q;
   logic        take;

   // Status outputs decode the state register only, so nothing combinational
   // reaches them from rx_valid.
   assign rx_ready = (state == S_LEN) || (state == S_HI) ||
                     (state == S_LO)  || (state == S_CSUM);
   assign cpu_hold = (state != S_DONE);
   assign done     = (state == S_DONE);
   assign error    = (state == S_ERR);
   assign take     = rx_valid && rx_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: datapath registers are reset along with the state so a reset
         // mid-load leaves no half-assembled word or stale sum behind.
         state      <= S_IDLE;
         sum        <= 8'h00;
         words_left <= 8'h00;
         addr_ptr   <= BASE_ADDR;
         hi_byte    <= 8'h00;
         word_q     <= 16'h0000;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= 16'h0000;
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state    <= S_LEN;
                  sum      <= 8'h00;
                  addr_ptr <= BASE_ADDR;
               end
            end
            S_LEN: begin
               if (take) begin
                  sum        <= sum + rx_data;
                  words_left <= rx_data;
                  state      <= (rx_data == 8'd0 || rx_data > 8'd128) ? S_ERR : S_HI;
               end
            end
            S_HI: begin
               if (take) begin
                  sum     <= sum + rx_data;
                  hi_byte <= rx_data;
                  state   <= S_LO;
               end
            end
            S_LO: begin
               if (take) begin
                  sum    <= sum + rx_data;
                  word_q <= {hi_byte, rx_data};
                  state  <= S_WRITE;
               end
            end
            S_WRITE: begin
               // The strobe is registered here, so it lands one cycle after WRITE.
               imem_we    <= 1'b1;
               imem_addr  <= addr_ptr;
               imem_wdata <= word_q;
               addr_ptr   <= addr_ptr + 8'd2;
               words_left <= words_left - 8'd1;
               state      <= (words_left == 8'd1) ? S_CSUM : S_HI;
            end
            S_CSUM: begin
               if (take) state <= (rx_data == sum) ? S_DONE : S_ERR;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; two instances (base 00 and FE)
// see the same byte stream and are compared with a stream-level reference model.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset, start, rx_valid;
   logic [7:0]  rx_data;
   logic        rdy0, we0, hold0, done0, err0;
   logic        rdy1, we1, hold1, done1, err1;
   logic [7:0]  addr0, addr1;
   logic [15:0] wd0, wd1;

   imem_loader #(.BASE_ADDR(8'h00)) dut0 (
      .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rdy0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0),
      .cpu_hold(hold0), .done(done0), .error(err0));

   imem_loader #(.BASE_ADDR(8'hFE)) dut1 (
      .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rdy1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
      .cpu_hold(hold1), .done(done1), .error(err1));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [7:0]  a;
      logic [15:0] d;
   } wr_t;

   wr_t        got0[$], got1[$];
   logic [7:0] stream[$];
   bit         pw0, pw1;
   int         viol0, viol1;

   // Write monitor: records every strobe cycle and flags strobes wider than one cycle.
   always @(negedge clk) begin
      if (we0) got0.push_back(wr_t'{addr0, wd0});
      if (we1) got1.push_back(wr_t'{addr1, wd1});
      if (we0 && pw0) viol0++;
      if (we1 && pw1) viol1++;
      pw0 = we0;
      pw1 = we1;
   end

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      bit   acc;
      logic rdy;
      int   gap;
      acc = 1'b0;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      rx_valid = 1'b0;
      repeat (gap) begin
         rx_data = 8'($urandom);
         @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data  = b;
      for (int t = 0; t < 40 && !acc; t++) begin
         @(negedge clk);
         rdy = rdy0;
         @(posedge clk); #1;
         if (rdy) acc = 1'b1;
      end
      rx_valid = 1'b0;
      check("byte_accept", 32'(acc), 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Replace the final byte of a well-formed stream with the correct checksum.
   task automatic fix_csum();
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < stream.size() - 1; i++) s = s + stream[i];
      stream[stream.size() - 1] = s;
   endtask

   task automatic run_load(input int gap, input bit tchk, input bit start_hi);
      int         n, nsend;
      bit         len_ok, ok;
      logic [7:0] s;
      logic [7:0] ea0, ea1;
      got0.delete();
      got1.delete();
      viol0 = 0;
      viol1 = 0;
      n      = int'(stream[0]);
      len_ok = (n >= 1) && (n <= 128);
      if (len_ok) begin
         s = 8'h00;
         for (int i = 0; i <= 2 * n; i++) s = s + stream[i];
         ok    = (stream[2 * n + 1] == s);
         nsend = 2 * n + 2;
      end else begin
         ok    = 1'b0;
         nsend = 1;
      end

      pulse_start();
      @(negedge clk);
      check("start_hold", 32'(hold0), 32'd1);
      check("start_done", 32'(done0), 32'd0);
      check("start_err",  32'(err0),  32'd0);
      check("start_rdy0", 32'(rdy0),  32'd1);
      check("start_rdy1", 32'(rdy1),  32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < nsend; i++) begin
         send_byte(stream[i], gap);
         if (i == 0 && start_hi && len_ok) pulse_start();
         if (tchk && len_ok && i >= 2 && (i % 2) == 0 && i <= 2 * n) begin
            @(negedge clk);
            check("we_early",     32'(we0),  32'd0);
            check("write_bubble", 32'(rdy0), 32'd0);
            @(negedge clk);
            check("we_pulse0", 32'(we0), 32'd1);
            check("we_pulse1", 32'(we1), 32'd1);
            @(posedge clk); #1;
         end
      end

      @(negedge clk);
      check("done0",   32'(done0), 32'(ok));
      check("error0",  32'(err0),  32'(!ok));
      check("hold0",   32'(hold0), 32'(!ok));
      check("rdy_end", 32'(rdy0),  32'd0);
      check("done1",   32'(done1), 32'(ok));
      check("error1",  32'(err1),  32'(!ok));
      check("hold1",   32'(hold1), 32'(!ok));
      repeat (2) @(posedge clk);
      #1;

      check("nwrites0", 32'(got0.size()), len_ok ? 32'(n) : 32'd0);
      check("nwrites1", 32'(got1.size()), len_ok ? 32'(n) : 32'd0);
      for (int i = 0; i < n && i < got0.size(); i++) begin
         ea0 = 8'(2 * i);
         check("addr0",  32'(got0[i].a), 32'(ea0));
         check("wdata0", 32'(got0[i].d), 32'({stream[1 + 2 * i], stream[2 + 2 * i]}));
      end
      for (int i = 0; i < n && i < got1.size(); i++) begin
         ea1 = 8'(254 + 2 * i);
         check("addr1",  32'(got1[i].a), 32'(ea1));
         check("wdata1", 32'(got1[i].d), 32'({stream[1 + 2 * i], stream[2 + 2 * i]}));
      end
      check("we_single0", 32'(viol0), 32'd0);
      check("we_single1", 32'(viol1), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset    = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #12;
      check("rst_rdy",   32'(rdy0),  32'd0);
      check("rst_we",    32'(we0),   32'd0);
      check("rst_addr0", 32'(addr0), 32'h00);
      check("rst_addr1", 32'(addr1), 32'hFE);
      check("rst_wdata", 32'(wd0),   32'd0);
      check("rst_hold",  32'(hold0), 32'd1);
      check("rst_done",  32'(done0), 32'd0);
      check("rst_err",   32'(err0),  32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Nominal image, back-to-back bytes with strobe timing checked.
      stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
      run_load(0, 1'b1, 1'b0);

      // Checksum mismatch.
      stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
      run_load(0, 1'b0, 1'b0);

      // Bad lengths.
      stream = '{8'h00};
      run_load(0, 1'b0, 1'b0);
      stream = '{8'h81};
      run_load(0, 1'b0, 1'b0);

      // Random stalls; dut1 wraps FE -> 00.
      stream = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAC};
      run_load(3, 1'b0, 1'b0);

      // Reset after the high byte of word 1.
      stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
      got0.delete();
      got1.delete();
      pulse_start();
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
      #3 reset = 1'b1;
      #1;
      check("mid_rst_hold",  32'(hold0), 32'd1);
      check("mid_rst_rdy",   32'(rdy0),  32'd0);
      check("mid_rst_we",    32'(we0),   32'd0);
      check("mid_rst_addr0", 32'(addr0), 32'h00);
      check("mid_rst_addr1", 32'(addr1), 32'hFE);
      check("mid_rst_done",  32'(done0), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_rst_writes0", 32'(got0.size()), 32'd1);
      check("mid_rst_writes1", 32'(got1.size()), 32'd1);
      check("mid_rst_idle",    32'(hold0),       32'd1);
      run_load(0, 1'b1, 1'b0);

      // Restart after DONE with a new image and a stray start during HI.
      stream = '{8'h02, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
      fix_csum();
      run_load(0, 1'b0, 1'b1);

      // Randomized images.
      for (int r = 0; r < 14; r++) begin
         if (r % 5 == 4) begin
            stream = '{((r % 2) != 0) ? 8'h00 : 8'($urandom_range(255, 129))};
         end else begin
            n = int'($urandom_range(6, 1));
            stream.delete();
            stream.push_back(8'(n));
            for (int i = 0; i < 2 * n; i++) stream.push_back(8'($urandom));
            stream.push_back(8'h00);
            fix_csum();
            if ($urandom_range(3, 0) == 0) stream[2 * n + 1] = stream[2 * n + 1] ^ 8'h01;
         end
         run_load(int'($urandom_range(2, 0)), (r % 3) == 0, (r % 4) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
